// File: rtl/gate_truth_sweeper_if.sv
// gate_truth_sweeper_if
//   Bundles the sweep handshake and the gate-block stimulus/response signals.
//   Optional feature macro: GATE_SWEEP_ERR_COUNT_EN (adds err_cnt).
// Signals:
//   start   - sweep request (to sweeper)
//   in1/in2 - stimulus A/B to the gate block (from sweeper)
//   gate_in - eight gate outputs under test (to sweeper)
//             [0] and [1] or [2] xor [3] nand [4] nor [5] xnor [6] ~in1 [7] ~in2
//   vec_idx - current vector index 0..3
//   busy    - sweep in progress
//   done    - one-cycle end-of-sweep pulse
//   pass    - high iff err_map == 0, valid from done
//   err_map - sticky per-gate mismatch map, gate_in bit order
//   err_cnt - (optional) total mismatching bits over the sweep
// Modports: master = sweeper side, slave = environment side.
interface gate_truth_sweeper_if;
  logic       start;
  logic       in1;
  logic       in2;
  logic [7:0] gate_in;
  logic [1:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_map;
`ifdef GATE_SWEEP_ERR_COUNT_EN
  logic [5:0] err_cnt;

  modport master (
    input  start, gate_in,
    output in1, in2, vec_idx, busy, done, pass, err_map, err_cnt
  );
  modport slave (
    output start, gate_in,
    input  in1, in2, vec_idx, busy, done, pass, err_map, err_cnt
  );
`else
  modport master (
    input  start, gate_in,
    output in1, in2, vec_idx, busy, done, pass, err_map
  );
  modport slave (
    output start, gate_in,
    input  in1, in2, vec_idx, busy, done, pass, err_map
  );
`endif
endinterface

// File: rtl/gate_truth_sweeper.sv
// gate_truth_sweeper
//   Drives the two-input gate block through all four input combinations,
//   waits SETTLE_CYCLES after each, then compares the eight fed-back gate
//   outputs against the truth table. Reports a sticky mismatch map and a
//   pass flag with a one-cycle done pulse.
//   Optional feature macro: GATE_SWEEP_ERR_COUNT_EN adds err_cnt, the total
//   number of mismatching bits over a sweep.
// Parameters:
//   SETTLE_CYCLES - idle cycles between driving a vector and sampling it (0..255)
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - gate_truth_sweeper_if.master (start, in1, in2, gate_in, vec_idx,
//         busy, done, pass, err_map[, err_cnt])
module gate_truth_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_truth_sweeper_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam bit         LP_NO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [7:0] LP_LAST      = LP_NO_SETTLE ? 8'd0 : 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_cnt;
  logic [1:0] r_vec_idx;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] r_err_map;

  logic [7:0] w_cnt_nxt;
  logic [1:0] w_vec_idx_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pass_nxt;
  logic [7:0] w_err_map_nxt;

  logic       w_a;
  logic       w_b;
  logic [7:0] w_expected;
  logic [7:0] w_mismatch;
  logic [7:0] w_err_acc;

  // Stimulus is taken straight from the registered vector index, so in1/in2
  // are register outputs and change only where vec_idx does.
  assign w_a = r_vec_idx[1];
  assign w_b = r_vec_idx[0];

  assign w_expected = {~w_b, ~w_a, ~(w_a ^ w_b), ~(w_a | w_b), ~(w_a & w_b),
                       w_a ^ w_b, w_a | w_b, w_a & w_b};
  assign w_mismatch = bus.gate_in ^ w_expected;
  assign w_err_acc  = r_err_map | w_mismatch;

`ifdef GATE_SWEEP_ERR_COUNT_EN
  logic [5:0] r_err_cnt;
  logic [5:0] w_err_cnt_nxt;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = LP_NO_SETTLE ? S_SAMPLE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == LP_LAST) begin
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (r_vec_idx == 2'd3) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = LP_NO_SETTLE ? S_SAMPLE : S_SETTLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs. done and pass are
  // produced on the edge entering DONE (pass from the final accumulated map),
  // so both are visible together for the whole DONE cycle.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_vec_idx_nxt = r_vec_idx;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_pass_nxt    = r_pass;
    w_err_map_nxt = r_err_map;
`ifdef GATE_SWEEP_ERR_COUNT_EN
    w_err_cnt_nxt = r_err_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_cnt_nxt     = '0;
          w_vec_idx_nxt = '0;
          w_busy_nxt    = 1'b1;
          w_pass_nxt    = 1'b0;
          w_err_map_nxt = '0;
`ifdef GATE_SWEEP_ERR_COUNT_EN
          w_err_cnt_nxt = '0;
`endif
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
      S_SAMPLE: begin
        w_err_map_nxt = w_err_acc;
`ifdef GATE_SWEEP_ERR_COUNT_EN
        w_err_cnt_nxt = r_err_cnt + 6'(popcnt8(w_mismatch));
`endif
        if (r_vec_idx == 2'd3) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
          w_pass_nxt = (w_err_acc == 8'd0);
        end else begin
          w_vec_idx_nxt = r_vec_idx + 2'd1;
          w_cnt_nxt     = '0;
        end
      end
      default: ;
    endcase
  end

  // Output / datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_vec_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_map <= '0;
`ifdef GATE_SWEEP_ERR_COUNT_EN
      r_err_cnt <= '0;
`endif
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_vec_idx <= w_vec_idx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_err_map <= w_err_map_nxt;
`ifdef GATE_SWEEP_ERR_COUNT_EN
      r_err_cnt <= w_err_cnt_nxt;
`endif
    end
  end

  assign bus.in1     = w_a;
  assign bus.in2     = w_b;
  assign bus.vec_idx = r_vec_idx;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = r_pass;
  assign bus.err_map = r_err_map;
`ifdef GATE_SWEEP_ERR_COUNT_EN
  assign bus.err_cnt = r_err_cnt;
`endif

endmodule
